// File: rtl/csr_arb.sv
// csr_arb: round-robin arbiter placing N_REQ single-transaction requesters
// onto one CSR slave port (addr/be/wr_data/wr_en/rd_data).
//
// Ports
//   clk, rst_n      : clock; synchronous active-low reset
//   req_i           : per-requester level request
//   req_we_i        : per-requester 1 = write, 0 = read
//   req_addr_i      : flattened addresses, requester k at [k*A_WIDTH +: A_WIDTH]
//   req_be_i        : flattened byte enables
//   req_wr_data_i   : flattened write data
//   ack_o           : one-cycle completion pulse, at most one bit set
//   rd_data_o       : captured read data, valid in a read-ack cycle
//   csr_addr_o, csr_be_o, csr_wr_data_o, csr_wr_en_o : CSR master outputs
//   csr_rd_data_i   : CSR read data, valid RD_LATENCY cycles after address
//   dbg_state       : current FSM state (IDLE=0, WR=1, RD=2, RACK=3)
//
// Handshake: requester k raises req_i[k] with stable attributes and holds them
// until it sees ack_o[k]; req_i[k] still high in the cycle after the ack is a
// new transaction. A grant is never revoked, so ack follows even if req_i drops.
module csr_arb #(
  parameter int N_REQ      = 4,
  parameter int A_WIDTH    = 10,
  parameter int D_WIDTH    = 16,
  parameter int BE_WIDTH   = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       req_we_i,
  input  logic [N_REQ*A_WIDTH-1:0]  req_addr_i,
  input  logic [N_REQ*BE_WIDTH-1:0] req_be_i,
  input  logic [N_REQ*D_WIDTH-1:0]  req_wr_data_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [D_WIDTH-1:0]     rd_data_o,
  output logic [A_WIDTH-1:0]     csr_addr_o,
  output logic [BE_WIDTH-1:0]    csr_be_o,
  output logic [D_WIDTH-1:0]     csr_wr_data_o,
  output logic                   csr_wr_en_o,
  input  logic [D_WIDTH-1:0]     csr_rd_data_i,
  output logic [1:0]             dbg_state
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RACK = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant;   // also identifies the in-flight requester
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            rd_done;

  assign dbg_state = state;
  assign rd_done   = (cnt == CW'(RD_LATENCY - 1));

  // Search starts one past the previous winner, so last_grant = N_REQ-1
  // after reset makes requester 0 the first candidate.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    cand  = last_grant;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ack_o       = '0;
    csr_wr_en_o = 1'b0;
    case (state)
      IDLE: if (found) state_nxt = req_we_i[pick] ? WR : RD;
      WR: begin
        csr_wr_en_o = 1'b1;
        ack_o       = N_REQ'(1) << last_grant;
        state_nxt   = IDLE;
      end
      RD: if (rd_done) state_nxt = RACK;
      RACK: begin
        ack_o     = N_REQ'(1) << last_grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Attributes are captured only at grant, so the CSR address and byte
  // enables stay stable through the whole transaction, ack cycle included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant    <= GW'(N_REQ - 1);
      csr_addr_o    <= '0;
      csr_be_o      <= '0;
      csr_wr_data_o <= '0;
      rd_data_o     <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            last_grant    <= pick;
            csr_addr_o    <= req_addr_i[int'(pick)*A_WIDTH +: A_WIDTH];
            csr_be_o      <= req_be_i[int'(pick)*BE_WIDTH +: BE_WIDTH];
            csr_wr_data_o <= req_wr_data_i[int'(pick)*D_WIDTH +: D_WIDTH];
            cnt           <= '0;
          end
        end
        RD: begin
          if (rd_done) begin
            rd_data_o <= csr_rd_data_i;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_arb.sv
// tb_csr_arb: directed bench for csr_arb with a small CSR slave model and an
// expected-transaction queue checked on every acknowledged transaction.
module tb_csr_arb;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int RL = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0]      we;
  logic [N*AW-1:0]   addr_f;
  logic [N*BW-1:0]   be_f;
  logic [N*DW-1:0]   wd_f;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rd_data;
  logic [AW-1:0]     csr_addr;
  logic [BW-1:0]     csr_be;
  logic [DW-1:0]     csr_wd;
  logic              csr_we;
  logic [DW-1:0]     csr_rd;
  logic [1:0]        dbg_state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int n;

  // {we, requester index, addr, data}
  logic [29:0] exp_q[$];

  always #5 clk = ~clk;

  csr_arb #(
    .N_REQ(N), .A_WIDTH(AW), .D_WIDTH(DW), .BE_WIDTH(BW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req),
    .req_we_i(we),
    .req_addr_i(addr_f),
    .req_be_i(be_f),
    .req_wr_data_i(wd_f),
    .ack_o(ack),
    .rd_data_o(rd_data),
    .csr_addr_o(csr_addr),
    .csr_be_o(csr_be),
    .csr_wr_data_o(csr_wd),
    .csr_wr_en_o(csr_we),
    .csr_rd_data_i(csr_rd),
    .dbg_state(dbg_state)
  );

  // CSR slave: byte-enabled writes, one register stage on reads so data for
  // the address of cycle 1 is on csr_rd in cycle 2 (RD_LATENCY = 2).
  logic [DW-1:0] mem [0:1023];
  logic          slave_init;
  always @(posedge clk) begin
    if (slave_init !== 1'b1) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[10'h040] <= 16'h5A5A;
      slave_init   <= 1'b1;
    end else if (csr_we) begin
      if (csr_be[0]) mem[csr_addr][7:0]  <= csr_wd[7:0];
      if (csr_be[1]) mem[csr_addr][15:8] <= csr_wd[15:8];
    end
    csr_rd <= mem[csr_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] rec(input logic w, input int k,
                                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {w, 3'(k), a, d};
  endfunction

  task automatic sb_check();
    logic [2:0]  idx;
    logic [29:0] obs;
    idx = '0;
    if (csr_we) chk("wr_en_has_ack", 32'(ack != '0), 32'd1);
    if (ack !== '0) begin
      for (int i = 0; i < N; i++) if (ack[i]) idx = 3'(i);
      obs = {csr_we, idx, csr_addr, csr_we ? csr_wd : rd_data};
      chk("ack_onehot", 32'($countones(ack)), 32'd1);
      chk("sb_expected_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_txn", 32'(obs), 32'(exp_q.pop_front()));
    end
  endtask

  // All time advances here; every cycle runs the scoreboard.
  task automatic tick();
    @(negedge clk);
    cyc++;
    sb_check();
  endtask

  task automatic wait_ack(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (ack === '0 && cycles < 40);
    if (ack === '0) chk("ack_timeout", 32'(ack), 32'd1);
  endtask

  task automatic set_req(input int k, input logic w, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [DW-1:0] d);
    req[k]              = 1'b1;
    we[k]               = w;
    addr_f[k*AW +: AW]  = a;
    be_f[k*BW +: BW]    = b;
    wd_f[k*DW +: DW]    = d;
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    we     = '0;
    addr_f = '0;
    be_f   = '0;
    wd_f   = '0;
    repeat (3) tick();

    // Reset values
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_wr_en", 32'(csr_we), 32'd0);
    chk("rst_addr", 32'(csr_addr), 32'd0);
    chk("rst_be", 32'(csr_be), 32'd0);
    chk("rst_wr_data", 32'(csr_wd), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write from requester 1
    set_req(1, 1'b1, 10'h123, 2'b11, 16'hBEEF);
    exp_q.push_back(rec(1'b1, 1, 10'h123, 16'hBEEF));
    tick();
    chk("wr_en", 32'(csr_we), 32'd1);
    chk("wr_addr", 32'(csr_addr), 32'h123);
    chk("wr_be", 32'(csr_be), 32'h3);
    chk("wr_data", 32'(csr_wd), 32'hBEEF);
    chk("wr_ack", 32'(ack), 32'b0010);
    req[1] = 1'b0;
    tick();
    chk("wr_en_one_cycle", 32'(csr_we), 32'd0);
    chk("wr_ack_one_cycle", 32'(ack), 32'd0);

    // Single read from requester 2
    set_req(2, 1'b0, 10'h040, 2'b11, 16'h0000);
    exp_q.push_back(rec(1'b0, 2, 10'h040, 16'h5A5A));
    tick();
    chk("rd_state_c1", 32'(dbg_state), 32'(S_RD));
    chk("rd_addr_c1", 32'(csr_addr), 32'h040);
    chk("rd_ack_c1", 32'(ack), 32'd0);
    tick();
    chk("rd_addr_c2", 32'(csr_addr), 32'h040);
    chk("rd_ack_c2", 32'(ack), 32'd0);
    tick();
    chk("rd_ack_c3", 32'(ack), 32'b0100);
    chk("rd_data_c3", 32'(rd_data), 32'h5A5A);
    chk("rd_addr_c3", 32'(csr_addr), 32'h040);
    req[2] = 1'b0;
    tick();
    chk("rd_ack_after", 32'(ack), 32'd0);
    chk("rd_data_hold", 32'(rd_data), 32'h5A5A);

    // Round-robin: all four hold writes from reset
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 10'(10'h200 + k), 2'b11, 16'(16'hA000 + k));
    for (int j = 0; j < 6; j++) exp_q.push_back(rec(1'b1, j % N, 10'(10'h200 + j % N), 16'(16'hA000 + j % N)));
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      wait_ack(n);
      chk("rr_grant", 32'(ack), 32'(1 << (j % N)));
      chk("rr_gap", 32'(n), (j == 0) ? 32'd1 : 32'd2);
    end
    req = '0;
    tick();
    chk("rr_quiet", 32'(ack), 32'd0);

    // Wrap and priority: grant 3, then 0 and 2 together
    set_req(3, 1'b1, 10'h300, 2'b11, 16'hC003);
    exp_q.push_back(rec(1'b1, 3, 10'h300, 16'hC003));
    wait_ack(n);
    chk("wrap_grant3", 32'(ack), 32'b1000);
    req[3] = 1'b0;
    set_req(0, 1'b1, 10'h301, 2'b11, 16'hC100);
    set_req(2, 1'b1, 10'h302, 2'b11, 16'hC102);
    exp_q.push_back(rec(1'b1, 0, 10'h301, 16'hC100));
    exp_q.push_back(rec(1'b1, 2, 10'h302, 16'hC102));
    wait_ack(n);
    chk("wrap_first", 32'(ack), 32'b0001);
    req[0] = 1'b0;
    wait_ack(n);
    chk("wrap_second", 32'(ack), 32'b0100);
    chk("wrap_gap", 32'(n), 32'd2);
    req[2] = 1'b0;
    tick();

    // Reset in the second RD cycle drops the read
    set_req(1, 1'b0, 10'h123, 2'b11, 16'h0000);
    tick();
    chk("rrst_state_rd", 32'(dbg_state), 32'(S_RD));
    tick();
    rst_n = 1'b0;
    tick();
    chk("rrst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rrst_ack", 32'(ack), 32'd0);
    chk("rrst_addr", 32'(csr_addr), 32'd0);
    chk("rrst_rd_data", 32'(rd_data), 32'd0);
    chk("rrst_wr_en", 32'(csr_we), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back(rec(1'b0, 1, 10'h123, 16'hBEEF));
    wait_ack(n);
    chk("rrst_reissue_lat", 32'(n), 32'(RL + 1));
    chk("rrst_reissue_ack", 32'(ack), 32'b0010);
    chk("rrst_reissue_data", 32'(rd_data), 32'hBEEF);
    req[1] = 1'b0;
    tick();

    // Back-to-back transactions from requester 0
    set_req(0, 1'b1, 10'h010, 2'b01, 16'h1111);
    exp_q.push_back(rec(1'b1, 0, 10'h010, 16'h1111));
    exp_q.push_back(rec(1'b1, 0, 10'h011, 16'h2222));
    wait_ack(n);
    chk("b2b_ack1", 32'(ack), 32'b0001);
    set_req(0, 1'b1, 10'h011, 2'b10, 16'h2222);
    tick();
    chk("b2b_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("b2b_idle_ack", 32'(ack), 32'd0);
    tick();
    chk("b2b_wr_en2", 32'(csr_we), 32'd1);
    chk("b2b_addr2", 32'(csr_addr), 32'h011);
    chk("b2b_be2", 32'(csr_be), 32'h2);
    req[0] = 1'b0;
    tick();

    // Request withdrawn right after grant still completes
    set_req(3, 1'b0, 10'h040, 2'b01, 16'h0000);
    exp_q.push_back(rec(1'b0, 3, 10'h040, 16'h5A5A));
    tick();
    chk("wd_be", 32'(csr_be), 32'h1);
    req[3] = 1'b0;
    wait_ack(n);
    chk("wd_ack", 32'(ack), 32'b1000);
    chk("wd_lat", 32'(n), 32'(RL));

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
